// File: rtl/shift_seq_ctrl_if.sv
// Command channel of the shift sequencer: valid/ready handshake plus the
// command payload (operation, load data, repeat count, fill bit).
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_count,
    output cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_count,
    input  cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: accepts one command at a time (LOAD, SHR, SHL, ROTR) and
// drives mode / parallel_in / serial inputs of a universal shift register
// cycle by cycle, pulsing done at completion.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN. When defined, op 11 rotates
// right using q_fb[0]; otherwise op 11 completes at once like a zero count.
// Outputs are registered from the next state so they line up with the state
// register; serial_in_right is muxed straight from q_fb while rotating.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_ctrl_if.slave  cmd,
  input  logic [WIDTH-1:0] q_fb,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] parallel_in,
  output logic             serial_in_left,
  output logic             serial_in_right,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  logic [1:0]       state_r, state_next_s;
  logic [1:0]       op_r, op_next_s;
  logic [WIDTH-1:0] data_r, data_next_s;
  logic             fill_r, fill_next_s;
  logic [CNT_W-1:0] rem_r, rem_next_s;

  logic [1:0]       mode_r, mode_next_s;
  logic [WIDTH-1:0] pin_r, pin_next_s;
  logic             sil_r, sil_next_s;
  logic             sir_r, sir_next_s;
  logic             rot_r, rot_next_s;
  logic             busy_r, done_r;

  logic             accept_s;
  logic             zero_cnt_s;
  logic             unused_q_s;

  // Ready only in IDLE and never while reset is held low.
  assign cmd.cmd_ready = (state_r == ST_IDLE) && reset;
  assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;
  // A shift with no steps, or a rotate when rotation is compiled out, goes straight to DONE.
  assign zero_cnt_s    = (cmd.cmd_count == CNT_ZERO) || ((cmd.cmd_op == OP_ROTR) && !ROT_EN);

  // Next state and command latch; remaining counts down once per shift cycle.
  always_comb begin
    state_next_s = state_r;
    op_next_s    = op_r;
    data_next_s  = data_r;
    fill_next_s  = fill_r;
    rem_next_s   = rem_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          op_next_s   = cmd.cmd_op;
          data_next_s = cmd.cmd_data;
          fill_next_s = cmd.cmd_fill;
          rem_next_s  = cmd.cmd_count;
          if (cmd.cmd_op == OP_LOAD) begin
            state_next_s = ST_LOAD;
          end else if (zero_cnt_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_next_s = ST_DONE;
      end
      ST_SHIFT: begin
        rem_next_s = rem_r - CNT_ONE;
        if (rem_r == CNT_ONE) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state so the registered outputs match it.
  always_comb begin
    mode_next_s = MODE_HOLD;
    pin_next_s  = {WIDTH{1'b0}};
    sil_next_s  = 1'b0;
    sir_next_s  = 1'b0;
    rot_next_s  = 1'b0;
    case (state_next_s)
      ST_LOAD: begin
        mode_next_s = MODE_LOAD;
        pin_next_s  = data_next_s;
      end
      ST_SHIFT: begin
        case (op_next_s)
          OP_SHR: begin
            mode_next_s = MODE_RIGHT;
            sir_next_s  = fill_next_s;
          end
          OP_SHL: begin
            mode_next_s = MODE_LEFT;
            sil_next_s  = fill_next_s;
          end
          OP_ROTR: begin
            mode_next_s = MODE_RIGHT;
            rot_next_s  = 1'b1;
          end
          default: begin
            mode_next_s = MODE_HOLD;
          end
        endcase
      end
      default: begin
        mode_next_s = MODE_HOLD;
      end
    endcase
  end

  // State, latched command and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      op_r    <= 2'b00;
      data_r  <= {WIDTH{1'b0}};
      fill_r  <= 1'b0;
      rem_r   <= CNT_ZERO;
      mode_r  <= MODE_HOLD;
      pin_r   <= {WIDTH{1'b0}};
      sil_r   <= 1'b0;
      sir_r   <= 1'b0;
      rot_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      op_r    <= op_next_s;
      data_r  <= data_next_s;
      fill_r  <= fill_next_s;
      rem_r   <= rem_next_s;
      mode_r  <= mode_next_s;
      pin_r   <= pin_next_s;
      sil_r   <= sil_next_s;
      sir_r   <= sir_next_s;
      rot_r   <= rot_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  assign mode           = mode_r;
  assign parallel_in    = pin_r;
  assign serial_in_left = sil_r;
  assign busy           = busy_r;
  assign done           = done_r;

`ifdef SHIFT_SEQ_ROTATE_EN
  // While rotating, the bit leaving at q[0] re-enters at the MSB.
  assign serial_in_right = rot_r ? q_fb[0] : sir_r;
  assign unused_q_s      = ^q_fb[WIDTH-1:1];
`else
  assign serial_in_right = sir_r;
  assign unused_q_s      = ^{q_fb, rot_r};
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: a behavioural 4-bit universal
// shift register closes the q_fb loop, and a scoreboard queue holds the
// expected result of each command until its done pulse.
module tb_shift_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q_reg;
  logic [1:0] mode;
  logic [3:0] parallel_in;
  logic       serial_in_left;
  logic       serial_in_right;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [3:0] data;
    logic       fill;
    logic [1:0] mode;
    int         active;
    int         lat;
    logic [3:0] q;
  } exp_t;

  exp_t sb[$];

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd             (cmd_if),
    .q_fb            (q_reg),
    .mode            (mode),
    .parallel_in     (parallel_in),
    .serial_in_left  (serial_in_left),
    .serial_in_right (serial_in_right),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Behavioural universal shift register fed by the controller.
  always @(posedge clk) begin
    if (!reset) q_reg <= 4'b0000;
    else begin
      case (mode)
        2'b01:   q_reg <= {serial_in_right, q_reg[3:1]};
        2'b10:   q_reg <= {q_reg[2:0], serial_in_left};
        2'b11:   q_reg <= parallel_in;
        default: q_reg <= q_reg;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a command and push its expected behaviour onto the scoreboard.
  task automatic present_cmd(input string name, input logic [1:0] op, input logic [3:0] data,
                             input logic [3:0] count, input logic fill, input logic [3:0] exp_q);
    exp_t e;
    bit   zero;
    e.name = name; e.op = op; e.data = data; e.fill = fill; e.q = exp_q;
    zero = (count == 4'd0) || (op == 2'b11 && !ROT_EN);
    case (op)
      2'b00:   begin e.mode = 2'b11; e.active = 1; end
      2'b01:   begin e.mode = 2'b01; e.active = zero ? 0 : int'(count); end
      2'b10:   begin e.mode = 2'b10; e.active = zero ? 0 : int'(count); end
      default: begin e.mode = 2'b01; e.active = zero ? 0 : int'(count); end
    endcase
    e.lat = e.active + 1;
    sb.push_back(e);
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_count = count;
    cmd_if.cmd_fill  = fill;
    cmd_if.cmd_valid = 1'b1;
  endtask

  // Wait for ready, let the next edge accept, then drop valid.
  task automatic accept_cmd(output int waited);
    waited = 0;
    while (cmd_if.cmd_ready !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    n_cmp++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_if.cmd_ready, waited);
    end
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Follow one command from cycle 1 after accept to done, then the IDLE cycle.
  task automatic wait_done();
    exp_t       e;
    int         cyc, act;
    bit         mode_ok, side_ok, hs_ok;
    logic [1:0] em;
    logic [3:0] epin;
    logic       esil, esir;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: actual 0 entries, required 1");
      return;
    end
    e = sb.pop_front();
    cyc = 1; act = 0; mode_ok = 1'b1; side_ok = 1'b1; hs_ok = 1'b1;
    while (done !== 1'b1 && cyc <= 40) begin
      em   = (cyc <= e.active) ? e.mode : 2'b00;
      epin = (em == 2'b11) ? e.data : 4'b0000;
      esil = (em == 2'b10) ? e.fill : 1'b0;
      esir = (em == 2'b01) ? ((e.op == 2'b11) ? q_reg[0] : e.fill) : 1'b0;
      if (mode !== em) mode_ok = 1'b0;
      if (mode !== 2'b00) act++;
      if (parallel_in !== epin || serial_in_left !== esil || serial_in_right !== esir) side_ok = 1'b0;
      if (cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
      step();
      cyc++;
    end
    if (done !== 1'b1 || cyc != e.lat) begin
      n_bad++;
      $display("FAIL %s_latency: done seen=%b at cycle %0d, required cycle %0d", e.name, done, cyc, e.lat);
    end
    n_cmp++;
    if (!mode_ok || act != e.active) begin
      n_bad++;
      $display("FAIL %s_mode: %0d active cycles (sequence ok=%0d), required %0d of mode %b", e.name, act, mode_ok, e.active, e.mode);
    end
    n_cmp++;
    if (!side_ok) begin
      n_bad++;
      $display("FAIL %s_serial_parallel: last pin=%b sil=%b sir=%b, required op-driven values", e.name, parallel_in, serial_in_left, serial_in_right);
    end
    n_cmp++;
    if (!hs_ok) begin
      n_bad++;
      $display("FAIL %s_busy_ready: ready=%b busy=%b, required 0/1 while busy", e.name, cmd_if.cmd_ready, busy);
    end
    n_cmp++;
    if (q_reg !== e.q) begin
      n_bad++;
      $display("FAIL %s_q: actual %b, required %b", e.name, q_reg, e.q);
    end
    n_cmp++;
    if (mode !== 2'b00 || busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done_cycle: mode=%b busy=%b ready=%b, required 00/1/0", e.name, mode, busy, cmd_if.cmd_ready);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_return_idle: done=%b ready=%b busy=%b, required 0/1/0", e.name, done, cmd_if.cmd_ready, busy);
    end
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] data,
                         input logic [3:0] count, input logic fill, input logic [3:0] exp_q);
    int w;
    present_cmd(name, op, data, count, fill, exp_q);
    accept_cmd(w);
    wait_done();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'b00; cmd_if.cmd_data = 4'h0;
    cmd_if.cmd_count = 4'h0; cmd_if.cmd_fill = 1'b0;
    step();
    step();
    n_cmp++;
    if (mode !== 2'b00 || parallel_in !== 4'h0 || serial_in_left !== 1'b0 || serial_in_right !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: mode=%b pin=%b sil=%b sir=%b, required all 0", mode, parallel_in, serial_in_left, serial_in_right);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_handshake: busy=%b done=%b ready=%b, required 0/0/0", busy, done, cmd_if.cmd_ready);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1/0", cmd_if.cmd_ready, busy);
    end
  endtask

  task automatic test_load();
    run_cmd("load", 2'b00, 4'b1011, 4'd0, 1'b0, 4'b1011);
  endtask

  task automatic test_shr();
    run_cmd("shr", 2'b01, 4'b0000, 4'd2, 1'b0, 4'b0010);
  endtask

  task automatic test_shl();
    run_cmd("load_zero", 2'b00, 4'b0000, 4'd0, 1'b0, 4'b0000);
    run_cmd("shl", 2'b10, 4'b0000, 4'd3, 1'b1, 4'b0111);
  endtask

  task automatic test_rotr();
    run_cmd("load_one", 2'b00, 4'b0001, 4'd0, 1'b0, 4'b0001);
    run_cmd("rotr", 2'b11, 4'b0000, 4'd5, 1'b1, ROT_EN ? 4'b1000 : 4'b0001);
  endtask

  task automatic test_zero_count();
    run_cmd("load_a", 2'b00, 4'b1010, 4'd0, 1'b0, 4'b1010);
    run_cmd("shr_zero", 2'b01, 4'b0000, 4'd0, 1'b1, 4'b1010);
  endtask

  task automatic test_saturation();
    run_cmd("load_c", 2'b00, 4'b1100, 4'd0, 1'b0, 4'b1100);
    run_cmd("shr_max", 2'b01, 4'b0000, 4'd15, 1'b0, 4'b0000);
  endtask

  task automatic test_back_to_back();
    int w;
    run_cmd("load_b", 2'b00, 4'b1011, 4'd0, 1'b0, 4'b1011);
    present_cmd("b2b_shr", 2'b01, 4'b0000, 4'd2, 1'b0, 4'b0010);
    accept_cmd(w);
    present_cmd("b2b_load", 2'b00, 4'b0110, 4'd0, 1'b0, 4'b0110);
    wait_done();
    accept_cmd(w);
    n_cmp++;
    if (w != 0) begin
      n_bad++;
      $display("FAIL b2b_spacing: second accept waited %0d extra cycles, required 0", w);
    end
    wait_done();
  endtask

  task automatic test_reset_mid();
    int w;
    bit ok, no_done;
    run_cmd("load_z", 2'b00, 4'b0000, 4'd0, 1'b0, 4'b0000);
    cmd_if.cmd_op = 2'b10; cmd_if.cmd_data = 4'h0; cmd_if.cmd_count = 4'd10;
    cmd_if.cmd_fill = 1'b1; cmd_if.cmd_valid = 1'b1;
    accept_cmd(w);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (mode !== 2'b10 || done !== 1'b0) ok = 1'b0;
      step();
    end
    n_cmp++;
    if (!ok || q_reg !== 4'b0111) begin
      n_bad++;
      $display("FAIL mid_shifting: q=%b seq_ok=%0d, required q 0111 after 3 left shifts", q_reg, ok);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (mode !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_abort: mode=%b busy=%b done=%b ready=%b, required 00/0/0/0", mode, busy, done, cmd_if.cmd_ready);
    end
    step();
    no_done = (done === 1'b0) && (cmd_if.cmd_ready === 1'b0);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (cmd_if.cmd_ready !== 1'b1 || !no_done) begin
      n_bad++;
      $display("FAIL mid_reset_release: ready=%b held_ok=%0d, required 1/1", cmd_if.cmd_ready, no_done);
    end
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || mode !== 2'b00 || busy !== 1'b0) no_done = 1'b0;
      step();
    end
    n_cmp++;
    if (!no_done) begin
      n_bad++;
      $display("FAIL mid_no_done: controller active after aborted command, required quiet");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shr();
    test_shl();
    test_rotr();
    test_zero_count();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
